// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchronizer, falling-edge start detection,
// mid-bit sampling from a down-counter, and a valid/ack byte hand-off.
module uart_rx #(
    parameter logic [13:0] KBAUD = 14'd10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_DataBit,
    input  logic       in_Ack,
    output logic [7:0] out_DataByte,
    output logic       out_Valid,
    output logic       out_FrameErr,
    output logic       out_Overrun,
    output logic       out_Busy
);

    localparam int CW = $clog2(KBAUD);
    localparam logic [CW-1:0] HALF_LOAD = CW'(KBAUD / 2 - 14'd1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(KBAUD - 14'd1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_frame_err;
    logic            r_overrun;
    logic            r_busy;

    logic            w_rx_s;
    logic            w_start_edge;
    logic            w_event;

    assign w_rx_s       = r_sync2;
    assign w_start_edge = r_prev & ~r_sync2;
    assign w_event      = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_prev      <= 1'b1;
            r_cnt       <= '0;
            r_bitcnt    <= 3'd0;
            r_shift     <= 8'd0;
            r_data      <= 8'd0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sync1     <= in_DataBit;
            r_sync2     <= r_sync1;
            r_prev      <= r_sync2;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
            if (r_valid && in_Ack) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_state <= S_START;
                        r_cnt   <= HALF_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    // A start bit that is already high again at mid-bit is a glitch
                    if (w_event) begin
                        if (!w_rx_s) begin
                            r_state  <= S_DATA;
                            r_cnt    <= FULL_LOAD;
                            r_bitcnt <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_event) begin
                        r_shift[r_bitcnt] <= w_rx_s;
                        r_bitcnt          <= r_bitcnt + 3'd1;
                        r_cnt             <= FULL_LOAD;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (w_event) begin
                        r_data  <= r_shift;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        // Setting valid overrides a same-cycle ack clear above
                        if (w_rx_s) begin
                            r_valid   <= 1'b1;
                            r_overrun <= r_valid & ~in_Ack;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_DataByte = r_data;
    assign out_Valid    = r_valid;
    assign out_FrameErr = r_frame_err;
    assign out_Overrun  = r_overrun;
    assign out_Busy     = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a 16-clock bit period: timing, glitch,
// framing error, overrun, mid-frame reset and back-to-back frames.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       in_DataBit;
    logic       in_Ack;
    logic [7:0] out_DataByte;
    logic       out_Valid;
    logic       out_FrameErr;
    logic       out_Overrun;
    logic       out_Busy;

    int errors;
    int checks;
    int cyc;
    int busy_rise_cyc;
    int busy_fall_cyc;
    int busy_rise_cnt;
    int valid_rise_cyc;
    int valid_rise_cnt;
    int fe_cnt;
    int ov_cnt;
    logic prev_busy;
    logic prev_valid;
    logic [7:0] exp_q[$];

    uart_rx #(.KBAUD(14'd16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_DataBit   (in_DataBit),
        .in_Ack       (in_Ack),
        .out_DataByte (out_DataByte),
        .out_Valid    (out_Valid),
        .out_FrameErr (out_FrameErr),
        .out_Overrun  (out_Overrun),
        .out_Busy     (out_Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        prev_busy = 1'b0;
        prev_valid = 1'b0;
    end

    // Event recorder, sampled on the inactive edge
    always @(negedge clk) begin
        if (out_Busy && !prev_busy) begin
            busy_rise_cyc = cyc;
            busy_rise_cnt++;
        end
        if (!out_Busy && prev_busy) busy_fall_cyc = cyc;
        if (out_Valid && !prev_valid) begin
            valid_rise_cyc = cyc;
            valid_rise_cnt++;
        end
        if (out_FrameErr) fe_cnt++;
        if (out_Overrun) ov_cnt++;
        prev_busy = out_Busy;
        prev_valid = out_Valid;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One 8N1 frame, 16 clocks per bit, driven one clock at a time.
    // ack_k / rst_k select a clock index at which to pulse in_Ack / rst.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int ack_k, input int rst_k);
        int b;
        for (int k = 0; k < 160; k++) begin
            b = k / 16;
            if (b == 0)      in_DataBit = 1'b0;
            else if (b <= 8) in_DataBit = data[b-1];
            else             in_DataBit = stop_bit;
            if (ack_k >= 0) in_Ack = (k == ack_k);
            if (k == rst_k) rst = 1'b1;
            @(posedge clk);
            #1;
            if (k == rst_k) begin
                rst = 1'b0;
                check("rst_mid_data",  {24'd0, out_DataByte}, 32'h00);
                check("rst_mid_valid", {31'd0, out_Valid},    32'd0);
                check("rst_mid_busy",  {31'd0, out_Busy},     32'd0);
                check("rst_mid_fe",    {31'd0, out_FrameErr}, 32'd0);
                check("rst_mid_ov",    {31'd0, out_Overrun},  32'd0);
            end
        end
        if (ack_k >= 0) in_Ack = 1'b0;
    endtask

    task automatic ack_pulse();
        in_Ack = 1'b1;
        tick(1);
        in_Ack = 1'b0;
    endtask

    initial begin
        int c0;
        int d;
        int n;
        int fe0;
        int ov0;
        int vr0;
        int br0;
        logic [7:0] lb_bytes [4];

        errors = 0;
        checks = 0;
        cyc = 0;
        busy_rise_cnt = 0;
        valid_rise_cnt = 0;
        fe_cnt = 0;
        ov_cnt = 0;
        in_DataBit = 1'b1;
        in_Ack = 1'b0;
        rst = 1'b1;

        // Reset state
        tick(3);
        check("reset_data",  {24'd0, out_DataByte}, 32'h00);
        check("reset_valid", {31'd0, out_Valid},    32'd0);
        check("reset_busy",  {31'd0, out_Busy},     32'd0);
        check("reset_fe",    {31'd0, out_FrameErr}, 32'd0);
        check("reset_ov",    {31'd0, out_Overrun},  32'd0);
        rst = 1'b0;
        tick(20);

        // 0xA5: detection latency and valid timing
        fe0 = fe_cnt;
        c0 = cyc;
        send_frame(8'hA5, 1'b1, -1, -1);
        tick(4);
        check("a5_busy_latency", busy_rise_cyc - c0, 32'd3);
        d = valid_rise_cyc - busy_rise_cyc;
        check("a5_valid_at_152", {31'd0, (d >= 151 && d <= 153)}, 32'd1);
        check("a5_data",  {24'd0, out_DataByte}, 32'hA5);
        check("a5_valid", {31'd0, out_Valid},    32'd1);
        check("a5_no_fe", fe_cnt - fe0,          32'd0);
        ack_pulse();
        check("ack_clears_valid", {31'd0, out_Valid}, 32'd0);
        tick(5);

        // Start glitch: 4 low clocks
        fe0 = fe_cnt;
        vr0 = valid_rise_cnt;
        in_DataBit = 1'b0;
        tick(4);
        in_DataBit = 1'b1;
        tick(30);
        check("glitch_busy_len", busy_fall_cyc - busy_rise_cyc, 32'd8);
        check("glitch_busy_off", {31'd0, out_Busy}, 32'd0);
        check("glitch_no_valid", valid_rise_cnt - vr0, 32'd0);
        check("glitch_no_fe",    fe_cnt - fe0,         32'd0);

        // Framing error, then line held low (break)
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, -1, -1);
        br0 = busy_rise_cnt;
        tick(50);
        check("fe_pulse_once", fe_cnt - fe0, 32'd1);
        check("fe_data",  {24'd0, out_DataByte}, 32'h3C);
        check("fe_valid", {31'd0, out_Valid},    32'd0);
        check("break_no_start", busy_rise_cnt - br0, 32'd0);
        in_DataBit = 1'b1;
        tick(20);
        check("break_release_no_start", busy_rise_cnt - br0, 32'd0);

        // Overrun: two frames with no ack
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, -1, -1);
        check("ov_first_none", ov_cnt - ov0, 32'd0);
        send_frame(8'h22, 1'b1, -1, -1);
        tick(2);
        check("ov_pulse_once", ov_cnt - ov0, 32'd1);
        check("ov_data",  {24'd0, out_DataByte}, 32'h22);
        check("ov_valid", {31'd0, out_Valid},    32'd1);
        ack_pulse();
        tick(5);

        // Ack in exactly the second stop-event cycle: set wins, no overrun
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, 154, -1);
        tick(2);
        check("ack_stop_no_ov", ov_cnt - ov0, 32'd0);
        check("ack_stop_valid", {31'd0, out_Valid},    32'd1);
        check("ack_stop_data",  {24'd0, out_DataByte}, 32'h22);

        // Reset during data bit 4 (valid is still 1 from above)
        vr0 = valid_rise_cnt;
        send_frame(8'hFF, 1'b1, -1, 85);
        tick(10);
        check("rst_frame_dropped", valid_rise_cnt - vr0, 32'd0);
        check("rst_valid_low",     {31'd0, out_Valid},   32'd0);
        send_frame(8'hFF, 1'b1, -1, -1);
        tick(2);
        check("post_rst_valid", {31'd0, out_Valid},    32'd1);
        check("post_rst_data",  {24'd0, out_DataByte}, 32'hFF);
        ack_pulse();
        tick(10);

        // Back-to-back frames from a modelled transmitter
        lb_bytes[0] = 8'h00;
        lb_bytes[1] = 8'hFF;
        lb_bytes[2] = 8'h55;
        lb_bytes[3] = 8'h80;
        for (int i = 0; i < 4; i++) exp_q.push_back(lb_bytes[i]);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        fork
            begin
                for (int i = 0; i < 4; i++) send_frame(lb_bytes[i], 1'b1, -1, -1);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    n = 0;
                    while (!out_Valid && n < 400) begin
                        @(negedge clk);
                        n++;
                    end
                    check("lb_wait", {31'd0, (n < 400)}, 32'd1);
                    if (exp_q.size() > 0) check("lb_data", {24'd0, out_DataByte}, {24'd0, exp_q.pop_front()});
                    in_Ack = 1'b1;
                    @(posedge clk);
                    #1;
                    in_Ack = 1'b0;
                end
            end
        join
        tick(5);
        check("lb_no_fe", fe_cnt - fe0, 32'd0);
        check("lb_no_ov", ov_cnt - ov0, 32'd0);
        check("lb_all_received", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
